// File: rtl/dram_controller_if.sv
// 68030-side bus bundle between the CPU glue and the FPM SIMM controller.
// The master modport drives the CPU cycle; the slave modport is the controller.
interface dram_controller_if;
  logic        n_simm;
  logic        n_as;
  logic        rn_w;
  logic [31:0] addr;
  logic [1:0]  siz;
  logic [1:0]  n_dsack;
  logic [3:0]  n_ras0;
  logic [3:0]  n_ras1;
  logic [3:0]  n_cas;
  logic        n_simm_we;
  logic [11:0] simm_addr;
  logic        refresh_busy;

  modport master (
    output n_simm, n_as, rn_w, addr, siz,
    input  n_dsack, n_ras0, n_ras1, n_cas, n_simm_we, simm_addr, refresh_busy
  );

  modport slave (
    input  n_simm, n_as, rn_w, addr, siz,
    output n_dsack, n_ras0, n_ras1, n_cas, n_simm_we, simm_addr, refresh_busy
  );
endinterface

// File: rtl/dram_controller.sv
// FPM SIMM sequencer for 68030 cycles: RAS/CAS timing, row/column mux,
// byte-lane CAS, DSACK generation and CAS-before-RAS refresh arbitration.
module dram_controller #(
  parameter int unsigned REFRESH_INTERVAL = 500,
  parameter int unsigned RAS_TO_CAS       = 1,
  parameter int unsigned CAS_CYCLES       = 2,
  parameter int unsigned PRECHARGE_CYCLES = 2,
  parameter int unsigned COL_LSB          = 2,
  parameter int unsigned ROW_LSB          = 14,
  parameter int unsigned BANK_BIT         = 26
) (
  input  logic               clock,
  input  logic               n_reset,
  dram_controller_if.slave   bus
);

  localparam int unsigned REF_W          = $clog2(REFRESH_INTERVAL);
  localparam int unsigned CNT_W          = 3;
  localparam int unsigned AW             = 12;
  localparam int unsigned REF_RAS_CYCLES = 3;

  typedef enum logic [2:0] {IDLE, ROW, COL, DSACK, PRE, REF_CAS, REF_RAS} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REF_W-1:0]  ref_cnt_q;
  logic              ref_expire;
  logic              pending_q, pending_d;
  logic              bank_q, bank_d;
  logic              rn_w_q, rn_w_d;
  logic [AW-1:0]     row_q, row_d, col_q, col_d;
  logic [1:0]        a_lo_q, a_lo_d, siz_q, siz_d;
  logic [3:0]        lanes;
  logic [3:0]        ras0_q, ras0_d, ras1_q, ras1_d, cas_q, cas_d;
  logic              we_q, we_d;
  logic [1:0]        dsack_q, dsack_d;
  logic [AW-1:0]     simm_addr_q, simm_addr_d;
  logic              busy_q, busy_d;
  logic              addr_unused;

  assign addr_unused = ^bus.addr;

  // 68030 32-bit port byte-lane enables (active high) for writes
  function automatic logic [3:0] write_lanes(input logic [1:0] a, input logic [1:0] s);
    logic [3:0] l;
    l[3] = ~a[1] & ~a[0];
    l[2] = (~a[1] & a[0]) | (~a[1] & ~s[0]) | (~a[1] & s[1]);
    l[1] = (a[1] & ~a[0]) | (~a[1] & ~s[1] & ~s[0]) | (~a[1] & s[1] & s[0])
         | (~a[1] & a[0] & ~s[0]);
    l[0] = (a[1] & a[0]) | (a[0] & s[0] & s[1]) | (~s[0] & ~s[1]) | (a[1] & s[1]);
    return l;
  endfunction

  // Free-running refresh interval timer
  assign ref_expire = (ref_cnt_q == REF_W'(REFRESH_INTERVAL - 1));

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)        ref_cnt_q <= '0;
    else if (ref_expire) ref_cnt_q <= '0;
    else                 ref_cnt_q <= ref_cnt_q + REF_W'(1);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      bank_q      <= 1'b0;
      rn_w_q      <= 1'b1;
      row_q       <= '0;
      col_q       <= '0;
      a_lo_q      <= '0;
      siz_q       <= '0;
      ras0_q      <= '1;
      ras1_q      <= '1;
      cas_q       <= '1;
      we_q        <= 1'b1;
      dsack_q     <= 2'b11;
      simm_addr_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      bank_q      <= bank_d;
      rn_w_q      <= rn_w_d;
      row_q       <= row_d;
      col_q       <= col_d;
      a_lo_q      <= a_lo_d;
      siz_q       <= siz_d;
      ras0_q      <= ras0_d;
      ras1_q      <= ras1_d;
      cas_q       <= cas_d;
      we_q        <= we_d;
      dsack_q     <= dsack_d;
      simm_addr_q <= simm_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, cycle latch, and outputs decoded from the state being entered
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bank_d      = bank_q;
    rn_w_d      = rn_w_q;
    row_d       = row_q;
    col_d       = col_q;
    a_lo_d      = a_lo_q;
    siz_d       = siz_q;
    ras0_d      = '1;
    ras1_d      = '1;
    cas_d       = '1;
    we_d        = 1'b1;
    dsack_d     = 2'b11;
    simm_addr_d = simm_addr_q;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = REF_CAS;
        end else if (!bus.n_as && !bus.n_simm) begin
          state_d = ROW;
          bank_d  = bus.addr[BANK_BIT];
          rn_w_d  = bus.rn_w;
          row_d   = bus.addr[ROW_LSB +: AW];
          col_d   = bus.addr[COL_LSB +: AW];
          a_lo_d  = bus.addr[1:0];
          siz_d   = bus.siz;
        end
      end
      ROW: begin
        if (bus.n_as)                                 state_d = PRE;
        else if (cnt_q == CNT_W'(RAS_TO_CAS - 1))     state_d = COL;
      end
      COL: begin
        if (bus.n_as)                                 state_d = PRE;
        else if (cnt_q == CNT_W'(CAS_CYCLES))         state_d = DSACK;
      end
      DSACK: if (bus.n_as) state_d = PRE;
      PRE:   if (cnt_q == CNT_W'(PRECHARGE_CYCLES - 1)) state_d = IDLE;
      REF_CAS: state_d = REF_RAS;
      REF_RAS: if (cnt_q == CNT_W'(REF_RAS_CYCLES - 1)) state_d = PRE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // An expiry while a request is already pending is simply lost
    pending_d = (state_d == REF_CAS && state_q != REF_CAS) ? 1'b0 : (pending_q | ref_expire);

    lanes = rn_w_d ? 4'hF : write_lanes(a_lo_d, siz_d);

    case (state_d)
      ROW: begin
        ras0_d      = bank_d ? 4'hF : 4'h0;
        ras1_d      = bank_d ? 4'h0 : 4'hF;
        we_d        = rn_w_d;
        simm_addr_d = row_d;
      end
      COL: begin
        ras0_d      = bank_d ? 4'hF : 4'h0;
        ras1_d      = bank_d ? 4'h0 : 4'hF;
        we_d        = rn_w_d;
        simm_addr_d = col_d;
        cas_d       = (cnt_d != '0) ? ~lanes : 4'hF;
      end
      DSACK: begin
        ras0_d      = bank_d ? 4'hF : 4'h0;
        ras1_d      = bank_d ? 4'h0 : 4'hF;
        we_d        = rn_w_d;
        simm_addr_d = col_d;
        cas_d       = ~lanes;
        dsack_d     = 2'b00;
      end
      REF_CAS: begin
        cas_d  = 4'h0;
        busy_d = 1'b1;
      end
      REF_RAS: begin
        cas_d  = 4'h0;
        ras0_d = 4'h0;
        ras1_d = 4'h0;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.n_ras0       = ras0_q;
  assign bus.n_ras1       = ras1_q;
  assign bus.n_cas        = cas_q;
  assign bus.n_simm_we    = we_q;
  assign bus.n_dsack      = dsack_q;
  assign bus.simm_addr    = simm_addr_q;
  assign bus.refresh_busy = busy_q;

endmodule

// File: tb/tb_dram_controller.sv
// Bench for dram_controller: directed 68030 cycles, expected accesses queued
// on issue and checked by a negedge monitor when DSACK asserts.
module tb_dram_controller;

  logic clock = 1'b0;
  logic n_reset;

  dram_controller_if bus();

  dram_controller dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        bank;
    logic [11:0] row;
    logic [11:0] col;
    logic [11:0] col_pre;
    logic [3:0]  cas;
    logic        we_row;
    logic        we;
    logic [3:0]  cas_lat;
    logic [3:0]  ds_lat;
  } obs_t;

  obs_t exp_q[$];
  obs_t cur;
  int   total = 0;
  int   bad   = 0;
  int   cyc;
  int   ref_count = 0;
  int   ref_cyc   = 0;
  int   ras_low_cyc = 0;
  int   start_cyc = 0;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: tracks each access from RAS fall to DSACK and each refresh sequence
  logic [3:0]  p_ras0 = 4'hF, p_ras1 = 4'hF, p_cas = 4'hF;
  logic [1:0]  p_ds = 2'b11;
  logic [11:0] p_addr = 12'h0;

  always @(negedge clock) begin
    obs_t e;
    if (!n_reset) begin
      p_ras0 = 4'hF; p_ras1 = 4'hF; p_cas = 4'hF; p_ds = 2'b11; p_addr = 12'h0;
    end else begin
      check("dsack_legal", 64'(bus.n_dsack == 2'b00 || bus.n_dsack == 2'b11), 64'(1));
      check("bank_excl", 64'(!(bus.n_ras0 != 4'hF && bus.n_ras1 != 4'hF) || bus.refresh_busy), 64'(1));

      if (p_ras0 == 4'hF && p_ras1 == 4'hF && ((bus.n_ras0 == 4'h0) != (bus.n_ras1 == 4'h0))
          && !bus.refresh_busy) begin
        cur.bank   = (bus.n_ras1 == 4'h0);
        cur.row    = bus.simm_addr;
        cur.we_row = bus.n_simm_we;
        start_cyc  = cyc;
      end
      if (p_cas == 4'hF && bus.n_cas != 4'hF && !bus.refresh_busy) begin
        cur.col     = bus.simm_addr;
        cur.col_pre = p_addr;
        cur.cas     = bus.n_cas;
        cur.cas_lat = 4'(cyc - start_cyc);
      end
      if (p_ds == 2'b11 && bus.n_dsack == 2'b00) begin
        cur.we     = bus.n_simm_we;
        cur.ds_lat = 4'(cyc - start_cyc);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dsack_unexpected: got dsack=00 want none queued (cyc %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("access", 64'(cur), 64'(e));
        end
      end

      if (p_cas != 4'h0 && bus.n_cas == 4'h0 && bus.n_ras0 == 4'hF && bus.n_ras1 == 4'hF) begin
        ref_count++;
        ref_cyc = cyc;
        check("ref_cas_busy", 64'(bus.refresh_busy), 64'(1));
      end
      if (p_ras0 != 4'h0 && bus.n_ras0 == 4'h0 && bus.n_ras1 == 4'h0) begin
        ras_low_cyc = cyc;
        check("ref_cbr", 64'({32'(cyc - ref_cyc), bus.n_cas, bus.refresh_busy}),
              64'({32'd1, 4'h0, 1'b1}));
      end
      if (p_ras0 == 4'h0 && p_ras1 == 4'h0 && bus.n_ras0 == 4'hF) begin
        check("ref_hold", 64'({32'(cyc - ras_low_cyc), bus.n_ras1, bus.n_cas, bus.refresh_busy}),
              64'({32'd3, 4'hF, 4'hF, 1'b0}));
      end

      p_ras0 = bus.n_ras0; p_ras1 = bus.n_ras1; p_cas = bus.n_cas;
      p_ds   = bus.n_dsack; p_addr = bus.simm_addr;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.n_as   = 1'b1;
    bus.n_simm = 1'b1;
  endtask

  task automatic request(input logic [31:0] a, input logic [1:0] s, input logic rw);
    bus.addr   = a;
    bus.siz    = s;
    bus.rn_w   = rw;
    bus.n_simm = 1'b0;
    bus.n_as   = 1'b0;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({bus.n_ras0, bus.n_ras1, bus.n_cas, bus.n_simm_we, bus.n_dsack,
                bus.simm_addr, bus.refresh_busy});
  endfunction

  // Full CPU cycle; egap = clocks from request until one bank's RAS falls
  task automatic run_access(input logic [31:0] a, input logic [1:0] s, input logic rw,
                            input logic bank, input logic [11:0] row, input logic [11:0] col,
                            input logic [3:0] ecas, input int egap, input string nm);
    obs_t e;
    int   gap;
    int   n;
    e.bank = bank; e.row = row; e.col = col; e.col_pre = col; e.cas = ecas;
    e.we_row = rw; e.we = rw; e.cas_lat = 4'd2; e.ds_lat = 4'd4;
    exp_q.push_back(e);
    request(a, s, rw);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (((bus.n_ras0 == 4'hF) == (bus.n_ras1 == 4'hF)) && gap < 20);
    check({nm, "_start"}, 64'(gap), 64'(egap));
    n = 0;
    while (bus.n_dsack != 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_dsack"}, 64'(bus.n_dsack), 64'(0));
    idle_bus();
    tick();
    check({nm, "_release"}, 64'({bus.n_ras0, bus.n_ras1, bus.n_cas, bus.n_simm_we, bus.n_dsack}),
          64'({4'hF, 4'hF, 4'hF, 1'b1, 2'b11}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end by time %0t want end before it", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    n_reset = 1'b0;
    idle_bus();
    bus.addr = 32'h0;
    bus.siz  = 2'b00;
    bus.rn_w = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", all_out(), 64'({4'hF, 4'hF, 4'hF, 1'b1, 2'b11, 12'h000, 1'b0}));
    n_reset = 1'b1;

    // Read interrupted by reset while the column address is on the bus
    request(32'h0000_4008, 2'b00, 1'b1);
    tick();
    check("mid_row", 64'({bus.n_ras0, bus.n_ras1, bus.simm_addr}), 64'({4'h0, 4'hF, 12'h001}));
    tick();
    check("mid_col", 64'({bus.simm_addr, bus.n_cas}), 64'({12'h002, 4'hF}));
    #2 n_reset = 1'b0;
    #1 check("async_reset", all_out(), 64'({4'hF, 4'hF, 4'hF, 1'b1, 2'b11, 12'h000, 1'b0}));
    idle_bus();
    @(posedge clock);
    #1 n_reset = 1'b1;

    // Pending sets on edge 500 after release, refresh CAS follows on edge 501
    while (ref_count == 0 && cyc < 600) tick();
    check("first_refresh_cyc", 64'(ref_cyc), 64'(501));

    while (cyc < 510) tick();
    run_access(32'h0000_4008, 2'b00, 1'b1, 1'b0, 12'h001, 12'h002, 4'h0, 1, "long_read");
    run_access(32'h0400_0003, 2'b01, 1'b0, 1'b1, 12'h000, 12'h000, 4'hE, 3, "byte_write");
    run_access(32'h0000_C006, 2'b10, 1'b0, 1'b0, 12'h003, 12'h001, 4'hC, 3, "word_write");

    // Abort in ROW, issued straight after the previous cycle to also watch precharge
    request(32'h0000_4008, 2'b00, 1'b1);
    tick();
    check("pre_hold1", 64'({bus.n_ras0, bus.n_ras1}), 64'({4'hF, 4'hF}));
    tick();
    check("pre_hold2", 64'({bus.n_ras0, bus.n_ras1}), 64'({4'hF, 4'hF}));
    tick();
    check("abort_row", 64'({bus.n_ras0, bus.n_ras1, bus.simm_addr}), 64'({4'h0, 4'hF, 12'h001}));
    idle_bus();
    tick();
    check("abort_release", 64'({bus.n_ras0, bus.n_ras1, bus.n_cas, bus.n_dsack}),
          64'({4'hF, 4'hF, 4'hF, 2'b11}));
    run_access(32'h07FF_FFFC, 2'b00, 1'b1, 1'b1, 12'hFFF, 12'hFFF, 4'h0, 3, "boundary_read");

    // Access requested on the same edge that sees the second refresh pending
    while (cyc < 1000) tick();
    rc = ref_count;
    run_access(32'h0000_8010, 2'b00, 1'b0, 1'b0, 12'h002, 12'h004, 4'h0, 8, "refresh_first");
    check("refresh_before_access", 64'({32'(ref_count - rc), 32'(ref_cyc)}), 64'({32'd1, 32'd1001}));

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_controller.md
Name: dram_controller

Overview:
- Sequences the 72-pin FPM SIMM for 68030 bus cycles: RAS/CAS timing, row/column address multiplexing, byte-lane CAS, write enable and DSACK generation.
- Schedules periodic CAS-before-RAS refresh and arbitrates it against CPU accesses.
- Sits in the core glue logic behind the address decoder that produces n_simm.

Parameters:
- REFRESH_INTERVAL, 500, clocks between refresh requests (15.6 us at 32 MHz).
- RAS_TO_CAS, 1, clocks in ROW state before the column address is driven.
- CAS_CYCLES, 2, clocks CAS is held before DSACK asserts.
- PRECHARGE_CYCLES, 2, minimum clocks with all RAS high after any cycle.
- COL_LSB, 2, lowest address bit of the column field (addr[COL_LSB+11:COL_LSB]).
- ROW_LSB, 14, lowest address bit of the row field (addr[ROW_LSB+11:ROW_LSB]).
- BANK_BIT, 26, address bit selecting the bank: 0 = n_ras0, 1 = n_ras1.

Ports:
- clock  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- n_simm  in  1  decoded SIMM select, active low.
- n_as  in  1  68030 address strobe, active low.
- rn_w  in  1  1 = read, 0 = write.
- addr  in  32  CPU address.
- siz  in  2  68030 transfer size.
- n_dsack  out  2  cycle termination; 2'b00 = 32-bit port.
- n_ras0  out  4  bank 0 RAS, all four bits driven identically.
- n_ras1  out  4  bank 1 RAS, all four bits driven identically.
- n_cas  out  4  byte-lane CAS; [3] = D31-24 ... [0] = D7-0.
- n_simm_we  out  1  DRAM write enable, active low.
- simm_addr  out  12  multiplexed row/column address.
- refresh_busy  out  1  high while a refresh sequence is in progress (debug).

Behaviour:
- Reset, asynchronous and effective immediately, including mid-cycle:
  - all RAS/CAS, n_simm_we and n_dsack driven high;
  - simm_addr = 0; refresh_busy = 0;
  - state = IDLE; refresh counter = 0; refresh pending = 0.
- Refresh counter:
  - free-running from 0 to REFRESH_INTERVAL-1, then wraps to 0 and sets pending;
  - a further expiry while pending is still set is dropped; there is no queue;
  - pending clears on entry to REF_CAS.
- State IDLE:
  - if pending, go to REF_CAS; refresh has priority over an access sampled in the same cycle, and that access waits;
  - otherwise, if n_as=0 and n_simm=0, latch addr, rn_w and siz, then go to ROW.
- State ROW:
  - simm_addr = row field; the selected bank's RAS is low;
  - n_simm_we = rn_w, and stays so until the cycle ends;
  - after RAS_TO_CAS clocks, go to COL.
- State COL:
  - simm_addr = column field;
  - CAS asserts one clock after the column address is driven, and is held for CAS_CYCLES clocks;
  - then go to DSACK.
- State DSACK:
  - n_dsack = 00; RAS and CAS stay held;
  - remain here until n_as is sampled high;
  - then release n_dsack, CAS and RAS together and go to PRE.
- Abort: n_as high during ROW or COL goes straight to PRE. n_dsack is never asserted on an abort.
- State PRE:
  - all RAS and CAS high for PRECHARGE_CYCLES clocks, then IDLE;
  - a new access is never started before precharge completes.
- Refresh sequence:
  - REF_CAS: all four n_cas low, n_simm_we high, 1 clock;
  - REF_RAS: all eight RAS low, held 3 clocks;
  - then release all, go to PRE;
  - refresh_busy is high from REF_CAS through the end of REF_RAS.
- Byte lanes:
  - Reads assert all four CAS.
  - Writes use the standard 68030 32-bit port equations on the latched A1:A0 and siz:
    - D31-24 = /A1·/A0;
    - D23-16 = /A1·A0 + /A1·/SIZ0 + /A1·SIZ1;
    - D15-8 = A1·/A0 + /A1·/SIZ1·/SIZ0 + /A1·SIZ1·SIZ0 + /A1·A0·/SIZ0;
    - D7-0 = A1·A0 + A0·SIZ0·SIZ1 + /SIZ0·/SIZ1 + A1·SIZ1.
- Fixed rules:
  - n_ras0 and n_ras1 are never both low outside refresh;
  - n_dsack is never anything other than 11 or 00.

Test Plan:
- Reset mid-access:
  - Stimulus: deassert n_reset while in COL.
  - Required: all RAS/CAS/WE/DSACK go high the same instant, with no clock edge needed; after release, the first refresh occurs 500 clocks later.
- Longword read, addr=0x0000_4008, siz=00, rn_w=1:
  - row=0x001 on simm_addr with n_ras0=0, then col=0x002;
  - n_cas=0000; n_dsack=00 on clock 5 after latch;
  - negating n_as releases everything; PRE lasts 2 clocks.
- Byte write, addr=0x0400_0003, siz=01, rn_w=0:
  - n_ras1 low and n_ras0 high;
  - n_cas=1110; n_simm_we=0 from ROW through DSACK.
- Word write at A1:A0=10, siz=10:
  - n_cas=1100.
- Refresh vs access:
  - Stimulus: pending set in the same cycle as n_as=0/n_simm=0.
  - Required: refresh runs first (CAS low 1 clock before all RAS low), then PRE, then the access completes with n_dsack=00.
- Abort:
  - Stimulus: n_as high during ROW.
  - Required: no n_dsack assertion; RAS released; PRE 2 clocks; back in IDLE.
